// File: rtl/uart_rx_ctrl.sv
// MiniUart receive sequencer: sample-tick generator, byte drain FSM, FWFT FIFO, overrun flag, level irq.
// Optional idle timeout interrupt compiled in with `define UART_RX_TIMEOUT_EN.
module uart_rx_ctrl #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
`ifdef UART_RX_TIMEOUT_EN
  , parameter int TO_TICKS = 32
`endif
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_enable,
  input  logic [15:0]   div,
  output logic          en_rx,
  input  logic          rs,
  input  logic [7:0]    d_in,
  output logic          over_read,
  input  logic          rd_en,
  output logic [7:0]    rd_data,
  output logic          rx_empty,
  output logic          rx_full,
  output logic [AW:0]   rx_count,
  input  logic [AW:0]   irq_thresh,
  output logic          irq,
  output logic          overrun,
  input  logic          clr_ovr
);

  typedef enum logic [1:0] {S_IDLE, S_CAPTURE, S_ACK, S_WAIT_CLR} state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [15:0]   r_tcnt;
  logic          r_en_rx;
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rptr;
  logic [AW-1:0] r_wptr;
  logic [AW:0]   r_count;
  logic          r_ovr;
  logic          r_irq;
  logic          w_over_read;
  logic          w_capture;
  logic          w_pop;
  logic          w_space;
  logic          w_push;
  logic          w_timeout;
  logic          w_irq_next;

  always_ff @(posedge clk) begin
    if (!rst || !rx_enable) begin
      r_tcnt  <= '0;
      r_en_rx <= 1'b0;
    end else if (r_tcnt >= div) begin
      r_tcnt  <= '0;
      r_en_rx <= 1'b1;
    end else begin
      r_tcnt  <= r_tcnt + 16'd1;
      r_en_rx <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_next;
  end

  // Only leaving IDLE is gated by rx_enable so an in-flight byte is always acknowledged.
  always_comb begin
    w_state_next = r_state;
    w_over_read  = 1'b0;
    case (r_state)
      S_IDLE:     if (rs && rx_enable) w_state_next = S_CAPTURE;
      S_CAPTURE:  w_state_next = S_ACK;
      S_ACK: begin
        w_over_read  = 1'b1;
        w_state_next = S_WAIT_CLR;
      end
      S_WAIT_CLR: if (!rs) w_state_next = S_IDLE;
      default:    w_state_next = S_IDLE;
    endcase
  end

  assign rx_empty  = (r_count == '0);
  assign rx_full   = (r_count == (AW+1)'(DEPTH));
  assign w_capture = (r_state == S_CAPTURE);
  assign w_pop     = rd_en && !rx_empty;
  // A pop in the capture cycle frees the slot the incoming byte needs.
  assign w_space   = !rx_full || w_pop;
  assign w_push    = w_capture && w_space;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= d_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rptr  <= '0;
      r_wptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst)                      r_ovr <= 1'b0;
    else if (w_capture && !w_space) r_ovr <= 1'b1;
    else if (clr_ovr)              r_ovr <= 1'b0;
  end

`ifdef UART_RX_TIMEOUT_EN
  logic [7:0] r_idle_cnt;
  logic       r_timeout;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_idle_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_push || w_pop || rx_empty)
        r_idle_cnt <= '0;
      else if (r_en_rx && r_state == S_IDLE && r_idle_cnt != 8'hFF)
        r_idle_cnt <= r_idle_cnt + 8'd1;
      if (w_pop)                             r_timeout <= 1'b0;
      else if (r_idle_cnt == 8'(TO_TICKS))   r_timeout <= 1'b1;
    end
  end

  assign w_timeout = r_timeout;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_irq_next = ((irq_thresh != '0) && (r_count >= irq_thresh)) || r_ovr || w_timeout;

  always_ff @(posedge clk) begin
    if (!rst) r_irq <= 1'b0;
    else      r_irq <= w_irq_next;
  end

  assign en_rx     = r_en_rx;
  assign over_read = w_over_read;
  assign rd_data   = r_mem[r_rptr];
  assign rx_count  = r_count;
  assign overrun   = r_ovr;
  assign irq       = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: directed plan plus randomized byte/pop/clear traffic
// scored against a queue-based model of the receive buffer.
module tb_uart_rx_ctrl;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_enable = 1'b0;
  logic [15:0]   div = 16'd0;
  logic          en_rx;
  logic          rs = 1'b0;
  logic [7:0]    d_in = 8'd0;
  logic          over_read;
  logic          rd_en = 1'b0;
  logic [7:0]    rd_data;
  logic          rx_empty;
  logic          rx_full;
  logic [AW:0]   rx_count;
  logic [AW:0]   irq_thresh = '0;
  logic          irq;
  logic          overrun;
  logic          clr_ovr = 1'b0;

  uart_rx_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .rx_enable(rx_enable), .div(div), .en_rx(en_rx),
    .rs(rs), .d_in(d_in), .over_read(over_read), .rd_en(rd_en), .rd_data(rd_data),
    .rx_empty(rx_empty), .rx_full(rx_full), .rx_count(rx_count),
    .irq_thresh(irq_thresh), .irq(irq), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: the buffer as a queue plus a sticky overrun bit.
  logic [7:0] q[$];
  bit         m_ovr = 1'b0;
  logic       irq_at_ack;
  logic       irq_after_ack;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("[TB] ok   %s: %0h", tag, got);
    end
  endtask

  function automatic bit exp_irq();
    return ((irq_thresh != 0) && (q.size() >= int'(irq_thresh))) || m_ovr;
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; rs = 1'b0; rd_en = 1'b0; clr_ovr = 1'b0;
    tick(); tick();
    rst = 1'b1;
    q.delete(); m_ovr = 1'b0;
  endtask

  // Receiver-side handshake; optionally a CPU pop lands in the capture cycle.
  task automatic send_byte(input logic [7:0] b, input bit with_pop);
    rs = 1'b1; d_in = b;
    tick();
    chk("capture_no_ack", over_read, 1'b0);
    if (with_pop) begin
      if (q.size() > 0) chk("pop_during_capture", rd_data, q[0]);
      rd_en = 1'b1;
    end
    tick();
    rd_en = 1'b0;
    chk("ack_pulse", over_read, 1'b1);
    irq_at_ack = irq;
    if (with_pop && q.size() > 0) void'(q.pop_front());
    if (q.size() < DEPTH) q.push_back(b);
    else m_ovr = 1'b1;
    tick();
    chk("ack_one_cycle", over_read, 1'b0);
    irq_after_ack = irq;
    rs = 1'b0;
    tick();
  endtask

  task automatic pop_byte();
    if (q.size() > 0) chk("pop_data", rd_data, q[0]);
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    if (q.size() > 0) void'(q.pop_front());
  endtask

  task automatic clear_ovr();
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    m_ovr = 1'b0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, rx_count, q.size());
    chk({tag, "_empty"}, rx_empty, q.size() == 0);
    chk({tag, "_full"}, rx_full, q.size() == DEPTH);
    chk({tag, "_ovr"}, overrun, m_ovr);
    tick();
    chk({tag, "_irq"}, irq, exp_irq());
  endtask

  task automatic measure_period(input int d);
    int n;
    bit seen;
    div = 16'(d);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (en_rx) seen = 1'b1;
    end
    chk("tick_sync", seen, 1'b1);
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      n++;
      if (en_rx) seen = 1'b1;
    end
    chk("tick_period", n, d + 1);
  endtask

  initial begin
    // Reset and idle
    do_reset();
    chk("rst_empty", rx_empty, 1'b1);
    chk("rst_count", rx_count, 0);
    chk("rst_irq", irq, 1'b0);
    chk("rst_over_read", over_read, 1'b0);
    chk("rst_overrun", overrun, 1'b0);
    chk("rst_en_rx", en_rx, 1'b0);
    rx_enable = 1'b1;
    measure_period(3);
    measure_period(0);
    for (int i = 0; i < 4; i++) measure_period(int'($urandom_range(0, 20)));
    // Park the tick far away so the optional timeout stays quiet in the FIFO tests.
    div = 16'hFFFF;

    // Single byte
    send_byte(8'hA5, 1'b0);
    chk("single_data", rd_data, 8'hA5);
    check_state("single");
    pop_byte();
    check_state("single_popped");
    pop_byte();
    check_state("pop_empty_ignored");

    // Fill and overrun
    for (int i = 0; i <= DEPTH; i++) send_byte(8'(i), 1'b0);
    check_state("fill_ovr");
    for (int i = 0; i < DEPTH; i++) begin
      chk("fill_order", rd_data, 8'(i));
      pop_byte();
    end
    check_state("drained");
    clear_ovr();
    check_state("ovr_cleared");

    // Full with simultaneous pop
    for (int i = 0; i < DEPTH; i++) send_byte(8'($urandom), 1'b0);
    send_byte(8'h5A, 1'b1);
    check_state("full_pop");
    while (q.size() > 1) pop_byte();
    chk("last_is_5a", rd_data, 8'h5A);
    pop_byte();
    check_state("full_pop_drained");

    // Threshold
    irq_thresh = 5'd4;
    for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
    check_state("thr_3");
    send_byte(8'hC3, 1'b0);
    chk("thr_irq_at_ack", irq_at_ack, 1'b0);
    chk("thr_irq_next", irq_after_ack, 1'b1);
    pop_byte();
    check_state("thr_back_to_3");

    // Reset in the middle of the acknowledge
    rs = 1'b1; d_in = 8'h77;
    tick(); tick();
    chk("mid_ack_pre", over_read, 1'b1);
    rst = 1'b0;
    tick();
    rst = 1'b1; rs = 1'b0;
    q.delete(); m_ovr = 1'b0;
    chk("mid_ack_over_read", over_read, 1'b0);
    chk("mid_ack_empty", rx_empty, 1'b1);
    irq_thresh = '0;

    // Randomized traffic
    for (int t = 0; t < 150; t++) begin
      int r;
      r = int'($urandom_range(0, 9));
      if (t % 25 == 0) irq_thresh = 5'($urandom_range(0, DEPTH));
      if (r < 5)      send_byte(8'($urandom), 1'($urandom));
      else if (r < 8) pop_byte();
      else            clear_ovr();
      check_state("rand");
    end

`ifdef UART_RX_TIMEOUT_EN
    do_reset();
    irq_thresh = '0;
    div = 16'd0;
    send_byte(8'h3C, 1'b0);
    for (int i = 0; i < 20; i++) tick();
    chk("to_early", irq, 1'b0);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 100 && !seen; i++) begin
        tick();
        if (irq) seen = 1'b1;
      end
      chk("to_fires", seen, 1'b1);
    end
    pop_byte();
    tick();
    chk("to_cleared", irq, 1'b0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
